clk_rst_seq: RTL and testbench
==============================

# clk_rst_seq

Reset sequencer that sits directly downstream of the 50 MHz MMCM clock wrapper. It runs on the MMCM output clock, synchronizes the MMCM `locked` flag, waits for a programmable lock-stable interval, and then releases peripheral reset and CPU reset in a fixed order. It re-asserts both resets on loss of lock, supports a CPU-only soft reset, and exposes a saturating lock-loss counter for debug.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before peripheral reset release. Must be ≥1.
- `PERIPH_TO_CPU_CYCLES`, default 16: cycles from `periph_resetn` rise to `cpu_resetn` rise. Must be ≥1.
- `SOFT_RST_CYCLES`, default 64: width of a soft CPU reset. Must be ≥1.
- `CNT_W`, default 16: shared counter width. Every `*_CYCLES` value must fit in it.

Ports:
- `clk` in 1: MMCM output clock (`clk_out1`).
- `resetn` in 1: asynchronous, active-low reset; the same signal that drives the MMCM reset.
- `locked` in 1: MMCM lock flag. Asynchronous to `clk`.
- `soft_rst_req` in 1: single-cycle CPU soft-reset request.
- `periph_resetn` out 1: active-low peripheral reset.
- `cpu_resetn` out 1: active-low CPU reset.
- `lock_loss_cnt` out 8: count of lock losses after release, saturating.
- `state` out 3: FSM state, for debug.

## Operation
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low. `resetn` feeds an internal 2-flop synchronizer (asynchronous assert, synchronous deassert). All other flops reset from the synchronized reset.
- Reset values: `periph_resetn`=0, `cpu_resetn`=0, `lock_loss_cnt`=0, `state`=0 (WAIT_LOCK). Counter=0, both lock-sync flops=0.
- Lock synchronizer: `locked` passes through 2 flops to produce `locked_s`. The FSM uses only `locked_s`.
- State encodings: WAIT_LOCK=0, STABLE=1, REL_PERIPH=2, RUN=3, SOFT=4. States 5–7 are illegal and return to WAIT_LOCK.
- WAIT_LOCK: both resets low.
  - If `locked_s`=1, go to STABLE with cnt=0.
- STABLE: both resets low.
  - If `locked_s`=0, go to WAIT_LOCK. This is not counted as a lock loss.
  - Else if cnt==LOCK_STABLE_CYCLES-1, go to REL_PERIPH with cnt=0 and set `periph_resetn`=1.
  - Else cnt++.
- REL_PERIPH:
  - If cnt==PERIPH_TO_CPU_CYCLES-1, go to RUN and set `cpu_resetn`=1.
  - Else cnt++.
- RUN:
  - If `soft_rst_req`=1, go to SOFT with cnt=0 and set `cpu_resetn`=0. `periph_resetn` stays 1.
- SOFT:
  - If cnt==SOFT_RST_CYCLES-1, return to RUN and set `cpu_resetn`=1.
  - Else cnt++.
  - `soft_rst_req` is ignored in SOFT and does not restart the count.
  - `soft_rst_req` is also ignored in every state other than RUN.
- Lock loss: in REL_PERIPH, RUN or SOFT, `locked_s`=0 takes priority over every other transition.
  - Next state is WAIT_LOCK; both resets are driven 0 at that edge.
  - `lock_loss_cnt` increments, saturating at 255.
- `lock_loss_cnt` clears only on `resetn`.
- Output ordering: `cpu_resetn`=1 implies `periph_resetn`=1 in every cycle. No glitches: all outputs are registered.

## Timing
- Take E0 as the first `clk` edge that samples `locked`=1 with the internal reset released. Then `locked_s`=1 after E1, and STABLE is entered at E2.
- `periph_resetn` rises at E(LOCK_STABLE_CYCLES+2), provided `locked` stays high throughout.
- `cpu_resetn` rises exactly PERIPH_TO_CPU_CYCLES edges after `periph_resetn` rises.
- Soft reset: `cpu_resetn` falls at the edge that samples `soft_rst_req`, and stays low for exactly SOFT_RST_CYCLES cycles.
- Lock-loss latency: both resets fall at the 3rd edge after `locked` falls (2 sync edges plus 1 FSM edge).
- `resetn` low: all outputs go to their reset values immediately, with no clock required.
- Mid-sequence: a `locked` glitch of ≥2 cycles during STABLE restarts the full stable count.
- Simultaneous lock loss and `soft_rst_req` in RUN: lock loss wins, and the state becomes WAIT_LOCK.

## Test plan
- Power-up (LOCK_STABLE_CYCLES=4, PERIPH_TO_CPU_CYCLES=3): release `resetn`, raise `locked` before E0 -> `periph_resetn` rises at E6, `cpu_resetn` rises at E9, `state` goes 0→1→2→3, `lock_loss_cnt`=0.
- Glitch during STABLE: drop `locked` for 3 cycles after 2 stable cycles -> state returns to 0, `periph_resetn` rise is delayed by the full restart, `lock_loss_cnt` stays 0.
- Lock loss in RUN: drop `locked` -> both resets 0 on the 3rd edge, `state`=0, `lock_loss_cnt`=1. Re-lock -> full sequence repeats.
- Soft reset (SOFT_RST_CYCLES=5): pulse `soft_rst_req` in RUN -> `cpu_resetn` low exactly 5 cycles, `periph_resetn` held 1. A second pulse during SOFT does not extend the low time.
- Saturation and priority: 300 lock-loss events -> `lock_loss_cnt`=255. `soft_rst_req` coincident with lock loss -> `state`=0.
- Async reset mid-RUN: pulse `resetn` low with no clock edge -> outputs 0 and `lock_loss_cnt` 0 immediately. Sequence restarts after release.

Source files
------------

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: reset sequencer downstream of the MMCM clock wrapper.
// Synchronizes reset and MMCM lock, waits for a stable lock interval, then
// releases peripheral reset followed by CPU reset. Supports a CPU-only soft
// reset and counts lock losses (saturating) for debug.
module clk_rst_seq #(
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int PERIPH_TO_CPU_CYCLES = 16,
    parameter int SOFT_RST_CYCLES      = 64,
    parameter int CNT_W                = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       periph_resetn,
    output logic       cpu_resetn,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABLE     = 3'd1,
        REL_PERIPH = 3'd2,
        RUN        = 3'd3,
        SOFT       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] P2C_LAST    = CNT_W'(PERIPH_TO_CPU_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_RST_CYCLES - 1);

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [1:0]       lock_sync;
    logic             locked_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       loss_q, loss_d;
    logic             periph_q, periph_d;
    logic             cpu_q, cpu_d;

    // Reset synchronizer: asynchronous assert, synchronous deassert.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_sync <= '0;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Two-flop synchronizer for the asynchronous MMCM lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_sync <= '0;
        else        lock_sync <= {lock_sync[0], locked};
    end

    assign locked_s = lock_sync[1];

    // FSM state, shared counter, loss counter and registered reset outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            loss_q   <= '0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loss_q   <= loss_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
        end
    end

    // Next-state logic; output flops are derived from the next state so that
    // cpu_resetn can never be high without periph_resetn.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;

        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = REL_PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REL_PERIPH: begin
                if (cnt_q == P2C_LAST) state_d = RUN;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            RUN: begin
                if (soft_rst_req) begin
                    state_d = SOFT;
                    cnt_d   = '0;
                end
            end
            SOFT: begin
                if (cnt_q == SOFT_LAST) state_d = RUN;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Lock loss after release overrides every other transition.
        if ((state_q == REL_PERIPH || state_q == RUN || state_q == SOFT) && !locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end

        periph_d = (state_d == REL_PERIPH) || (state_d == RUN) || (state_d == SOFT);
        cpu_d    = (state_d == RUN);
    end

    assign periph_resetn = periph_q;
    assign cpu_resetn    = cpu_q;
    assign lock_loss_cnt = loss_q;
    assign state         = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed self-checking bench for clk_rst_seq with short sequencing intervals.
module tb_clk_rst_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       locked;
    logic       soft_rst_req;
    logic       periph_resetn;
    logic       cpu_resetn;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    clk_rst_seq #(
        .LOCK_STABLE_CYCLES  (4),
        .PERIPH_TO_CPU_CYCLES(3),
        .SOFT_RST_CYCLES     (5),
        .CNT_W               (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .locked       (locked),
        .soft_rst_req (soft_rst_req),
        .periph_resetn(periph_resetn),
        .cpu_resetn   (cpu_resetn),
        .lock_loss_cnt(lock_loss_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        locked       = 1'b0;
        soft_rst_req = 1'b0;
        step(3);
        check("rst_periph", 32'(periph_resetn), 0);
        check("rst_cpu",    32'(cpu_resetn),    0);
        check("rst_loss",   32'(lock_loss_cnt), 0);
        check("rst_state",  32'(state),         0);

        // Release reset; let the internal synchronizer finish before locking.
        resetn = 1'b1;
        step(3);
        locked = 1'b1;            // next edge is E0
        step(2);                  // after E1
        check("pu_e1_state", 32'(state), 0);
        step(1);                  // after E2
        check("pu_e2_state", 32'(state), 1);

        // Glitch: drop locked right after entering STABLE for 3 cycles.
        locked = 1'b0;
        step(2);                  // after E4: locked_s just fell, still STABLE
        check("gl_e4_state", 32'(state), 1);
        step(1);                  // after E5: FSM has seen locked_s=0
        check("gl_state", 32'(state), 0);
        check("gl_periph", 32'(periph_resetn), 0);
        locked = 1'b1;            // next edge is E0'
        step(6);                  // after E5'
        check("gl_e5_periph", 32'(periph_resetn), 0);
        step(1);                  // after E6'
        check("gl_e6_periph", 32'(periph_resetn), 1);
        check("gl_e6_state",  32'(state), 2);
        check("gl_e6_cpu",    32'(cpu_resetn), 0);
        step(2);                  // after E8'
        check("gl_e8_cpu", 32'(cpu_resetn), 0);
        step(1);                  // after E9'
        check("gl_e9_cpu",   32'(cpu_resetn), 1);
        check("gl_e9_state", 32'(state), 3);
        check("gl_loss",     32'(lock_loss_cnt), 0);

        // Soft reset, with a second request during SOFT that must be ignored.
        soft_rst_req = 1'b1;
        step(1);                  // S0
        soft_rst_req = 1'b0;
        check("sr_s0_cpu",    32'(cpu_resetn), 0);
        check("sr_s0_state",  32'(state), 4);
        check("sr_s0_periph", 32'(periph_resetn), 1);
        step(1);                  // S1
        soft_rst_req = 1'b1;
        step(1);                  // S2
        soft_rst_req = 1'b0;
        step(2);                  // S4
        check("sr_s4_cpu",   32'(cpu_resetn), 0);
        check("sr_s4_state", 32'(state), 4);
        step(1);                  // S5
        check("sr_s5_cpu",    32'(cpu_resetn), 1);
        check("sr_s5_state",  32'(state), 3);
        check("sr_s5_periph", 32'(periph_resetn), 1);

        // Lock loss in RUN: both resets fall on the 3rd edge.
        locked = 1'b0;
        step(2);                  // F2
        check("ll_f2_cpu",   32'(cpu_resetn), 1);
        check("ll_f2_state", 32'(state), 3);
        step(1);                  // F3
        check("ll_f3_cpu",    32'(cpu_resetn), 0);
        check("ll_f3_periph", 32'(periph_resetn), 0);
        check("ll_f3_state",  32'(state), 0);
        check("ll_f3_loss",   32'(lock_loss_cnt), 1);

        // Re-lock: full sequence repeats.
        locked = 1'b1;
        step(6);                  // after E5
        check("rl_e5_periph", 32'(periph_resetn), 0);
        step(1);                  // after E6
        check("rl_e6_periph", 32'(periph_resetn), 1);
        step(3);                  // after E9
        check("rl_e9_cpu",   32'(cpu_resetn), 1);
        check("rl_e9_state", 32'(state), 3);

        // Lock loss coincident with soft reset request: lock loss wins.
        locked = 1'b0;
        step(2);                  // F2
        soft_rst_req = 1'b1;
        step(1);                  // F3
        soft_rst_req = 1'b0;
        check("pr_state", 32'(state), 0);
        check("pr_cpu",   32'(cpu_resetn), 0);
        check("pr_loss",  32'(lock_loss_cnt), 2);

        // Saturation: 300 more lock losses from REL_PERIPH.
        for (int unsigned i = 1; i <= 300; i++) begin
            locked = 1'b1;
            step(7);              // after E6: REL_PERIPH
            locked = 1'b0;
            step(3);              // F3: back to WAIT_LOCK
            if (i == 252) check("sat_254", 32'(lock_loss_cnt), 254);
            if (i == 253) check("sat_255", 32'(lock_loss_cnt), 255);
        end
        check("sat_final", 32'(lock_loss_cnt), 255);
        check("sat_state", 32'(state), 0);

        // Async reset mid-RUN with no clock edge.
        locked = 1'b1;
        step(10);                 // after E9
        check("ar_run_cpu", 32'(cpu_resetn), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_periph", 32'(periph_resetn), 0);
        check("ar_cpu",    32'(cpu_resetn), 0);
        check("ar_loss",   32'(lock_loss_cnt), 0);
        check("ar_state",  32'(state), 0);
        step(2);
        resetn = 1'b1;            // T; sync releases at T+2, E0 = T+3
        step(8);                  // after T+8 = E5
        check("ar_e5_periph", 32'(periph_resetn), 0);
        step(1);                  // E6
        check("ar_e6_periph", 32'(periph_resetn), 1);
        step(3);                  // E9
        check("ar_e9_cpu",   32'(cpu_resetn), 1);
        check("ar_e9_state", 32'(state), 3);
        check("ar_e9_loss",  32'(lock_loss_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
